timer_mm_master: RTL and testbench
==================================

# timer_mm_master

Avalon-MM initiator that programs and services the interval timer peripheral (16-bit register slave, registers 0–5) on behalf of hardware logic, with no Nios involvement. It:
- accepts a period/mode command;
- writes the timer's stop, status, period and control registers;
- services each timeout interrupt by clearing status, optionally snapshotting the counter;
- reports a timeout count.

It sits between fabric control logic and the timer's s1 slave, driving the signals the slave consumes directly.

## Interface
Parameters:
- READ_LATENCY, 1, slave readdata latency in cycles.
- CNT_W, 16, width of tick_count.

Ports:
- clk  in  1  system clock; everything is sampled on rising edge.
- reset  in  1  asynchronous, active-high reset.
- cfg_valid  in  1  command valid.
- cfg_ready  out  1  high only in IDLE.
- cfg_period  in  32  timer period, written verbatim.
- cfg_continuous  in  1  1 = continuous mode, 0 = one-shot.
- stop_req  in  1  stop request; honoured only in RUN.
- irq_in  in  1  timer irq, level.
- m_address  out  3  slave register address.
- m_chipselect  out  1  slave chipselect.
- m_write_n  out  1  active-low write.
- m_writedata  out  16  write data.
- m_readdata  in  16  slave readdata.
- busy  out  1  high whenever the FSM is not in IDLE.
- tick_count  out  CNT_W  serviced-timeout counter.
- snap_valid  out  1  one-cycle pulse when snap_value updates.
- snap_value  out  32  last counter snapshot.

## Operation
- Bus idle values: m_chipselect=0, m_write_n=1, m_address=0, m_writedata=0.
- Each write state lasts exactly one cycle with m_chipselect=1 and m_write_n=0. There is no waitrequest.
- Reads: m_chipselect=1, m_write_n=1, address held READ_LATENCY+1 cycles, m_readdata captured on the last cycle.
- FSM states: IDLE, W_STOP, W_CLR0, W_PL, W_PH, W_CTRL, RUN, S_CLR, S_GUARD, [SN_WR, SN_RDL, SN_RDH], W_HALT.
- IDLE: when cfg_valid and cfg_ready are both high, latch period and mode, clear tick_count, go to W_STOP.
- Config sequence:
  - W_STOP writes (1, 0x0008).
  - W_CLR0 writes (0, 0x0000).
  - W_PL writes (2, period[15:0]).
  - W_PH writes (3, period[31:16]).
  - W_CTRL writes (1, {12'b0, 0, 1, cont, 1}): 0x0007 continuous, 0x0005 one-shot. Then go to RUN.
- RUN handling:
  - If stop_req: go to W_HALT, which writes (1, 0x0008), then IDLE. stop_req has priority over irq_in in the same cycle.
  - Else if irq_in: go to S_CLR, which writes (0, 0x0000); tick_count increments (wraps at 2^CNT_W).
- S_GUARD: one idle bus cycle; irq_in is ignored because the slave drops irq one cycle after the status write.
- After S_GUARD (or after the snapshot sequence): go to RUN if continuous, else IDLE (the timer has stopped itself).
- irq_in is sampled only in RUN. stop_req outside RUN is ignored.
- Reset mid-operation: FSM returns to IDLE and all outputs take reset values. No bus cleanup is issued; the slave is reset by its own domain.

## Timing
- Reset values:
  - cfg_ready=1; busy=0; tick_count=0; snap_valid=0; snap_value=0.
  - Bus outputs at idle values.
- Config: command accepted at cycle N. Writes occur at N+1..N+5; RUN is entered at N+6. cfg_ready is low from N+1 until IDLE.
- irq_in seen high in RUN at cycle T: status write at T+1, guard at T+2.
- Without snapshot: back in RUN at T+3.
- With snapshot (READ_LATENCY=1):
  - SN_WR at T+3.
  - SN_RDL at T+4..T+5 (address 4).
  - SN_RDH at T+6..T+7 (address 5).
  - snap_valid=1 and snap_value updated at T+8, the first cycle back in RUN/IDLE.
- stop_req high in RUN at cycle T: halt write at T+1, IDLE at T+2.
- All outputs are registered.

## Configuration
- TIMER_MASTER_SNAPSHOT_EN defined:
  - After S_GUARD, write (4, 0x0000) to latch the counter.
  - Read register 4 then register 5; snap_value = {reg5, reg4}; pulse snap_valid.
- Undefined:
  - The SN_* states are absent and S_GUARD goes directly to RUN/IDLE.
  - snap_valid is tied 0 and snap_value is tied 0.

## Test plan
- Reset mid-RUN: assert reset -> next cycle busy=0, cfg_ready=1, bus idle, tick_count=0.
- Config, continuous: cfg_period=0x00000009, continuous=1 -> writes (1,0x0008), (0,0x0000), (2,0x0009), (3,0x0000), (1,0x0007) on consecutive cycles; busy=1.
- Continuous servicing: irq_in raised 3 times in RUN -> three (0,0x0000) writes; tick_count=3; FSM remains in RUN; irq_in held 1 during S_GUARD does not cause a double count.
- One-shot: continuous=0 -> control write data 0x0005; after one irq, FSM returns to IDLE with tick_count=1.
- stop_req and irq_in high in the same RUN cycle -> (1,0x0008) write, IDLE two cycles later, tick_count unchanged.
- With TIMER_MASTER_SNAPSHOT_EN, slave returns 0x0004 for register 4 and 0x0001 for register 5 -> snap_value=0x00010004, snap_valid high exactly one cycle, 8 cycles after irq_in was sampled.

Source files
------------

// File: rtl/timer_mm_master.sv
// Avalon-MM initiator that configures and services the interval timer s1 slave.
// Optional counter snapshot after each timeout: define TIMER_MASTER_SNAPSHOT_EN.
module timer_mm_master #(
    parameter int READ_LATENCY = 1,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [31:0]      cfg_period,
    input  logic             cfg_continuous,
    input  logic             stop_req,
    input  logic             irq_in,
    output logic [2:0]       m_address,
    output logic             m_chipselect,
    output logic             m_write_n,
    output logic [15:0]      m_writedata,
    input  logic [15:0]      m_readdata,
    output logic             busy,
    output logic [CNT_W-1:0] tick_count,
    output logic             snap_valid,
    output logic [31:0]      snap_value
);

    typedef enum logic [3:0] {
        IDLE,
        W_STOP,
        W_CLR0,
        W_PL,
        W_PH,
        W_CTRL,
        RUN,
        S_CLR,
        S_GUARD,
        W_HALT
`ifdef TIMER_MASTER_SNAPSHOT_EN
        ,
        SN_WR,
        SN_RDL,
        SN_RDH
`endif
    } state_t;

    state_t      state, state_d;
    logic [31:0] period_q;
    logic        cont_q;
    logic        accept;
    logic        cs_d, wn_d;
    logic [2:0]  addr_d;
    logic [15:0] wd_d;

    assign accept = cfg_valid && cfg_ready;

`ifdef TIMER_MASTER_SNAPSHOT_EN
    localparam int RC_W = $clog2(READ_LATENCY + 1) + 1;
    logic [RC_W-1:0] rd_cnt;
    logic            rd_last;
    logic [15:0]     snap_lo;

    assign rd_last = (rd_cnt == RC_W'(READ_LATENCY));
`else
    logic unused_readdata;
    assign unused_readdata = ^m_readdata;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (accept) state_d = W_STOP;
            W_STOP:  state_d = W_CLR0;
            W_CLR0:  state_d = W_PL;
            W_PL:    state_d = W_PH;
            W_PH:    state_d = W_CTRL;
            W_CTRL:  state_d = RUN;
            // stop_req wins over a simultaneous timeout
            RUN: begin
                if (stop_req)    state_d = W_HALT;
                else if (irq_in) state_d = S_CLR;
            end
            S_CLR:   state_d = S_GUARD;
`ifdef TIMER_MASTER_SNAPSHOT_EN
            S_GUARD: state_d = SN_WR;
            SN_WR:   state_d = SN_RDL;
            SN_RDL:  if (rd_last) state_d = SN_RDH;
            SN_RDH:  if (rd_last) state_d = cont_q ? RUN : IDLE;
`else
            S_GUARD: state_d = cont_q ? RUN : IDLE;
`endif
            W_HALT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Bus values are decoded from the upcoming state so the pins come straight from flops
    always_comb begin
        cs_d   = 1'b0;
        wn_d   = 1'b1;
        addr_d = 3'd0;
        wd_d   = 16'h0000;
        case (state_d)
            W_STOP, W_HALT: begin
                cs_d = 1'b1; wn_d = 1'b0; addr_d = 3'd1; wd_d = 16'h0008;
            end
            W_CLR0, S_CLR: begin
                cs_d = 1'b1; wn_d = 1'b0; addr_d = 3'd0;
            end
            W_PL: begin
                cs_d = 1'b1; wn_d = 1'b0; addr_d = 3'd2; wd_d = period_q[15:0];
            end
            W_PH: begin
                cs_d = 1'b1; wn_d = 1'b0; addr_d = 3'd3; wd_d = period_q[31:16];
            end
            W_CTRL: begin
                cs_d = 1'b1; wn_d = 1'b0; addr_d = 3'd1;
                wd_d = {12'b0, 1'b0, 1'b1, cont_q, 1'b1};
            end
`ifdef TIMER_MASTER_SNAPSHOT_EN
            SN_WR: begin
                cs_d = 1'b1; wn_d = 1'b0; addr_d = 3'd4;
            end
            SN_RDL: begin
                cs_d = 1'b1; addr_d = 3'd4;
            end
            SN_RDH: begin
                cs_d = 1'b1; addr_d = 3'd5;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            period_q <= cfg_period;
            cont_q   <= cfg_continuous;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m_chipselect <= 1'b0;
            m_write_n    <= 1'b1;
            m_address    <= 3'd0;
            m_writedata  <= 16'h0000;
            cfg_ready    <= 1'b1;
            busy         <= 1'b0;
            tick_count   <= '0;
        end else begin
            m_chipselect <= cs_d;
            m_write_n    <= wn_d;
            m_address    <= addr_d;
            m_writedata  <= wd_d;
            cfg_ready    <= (state_d == IDLE);
            busy         <= (state_d != IDLE);
            if (accept)
                tick_count <= '0;
            else if (state == RUN && state_d == S_CLR)
                tick_count <= tick_count + 1'b1;
        end
    end

`ifdef TIMER_MASTER_SNAPSHOT_EN
    // Each read phase holds its address READ_LATENCY+1 cycles; data is taken on the last one
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_cnt     <= '0;
            snap_lo    <= 16'h0000;
            snap_valid <= 1'b0;
            snap_value <= 32'h0000_0000;
        end else begin
            snap_valid <= 1'b0;
            if ((state == SN_RDL || state == SN_RDH) && !rd_last)
                rd_cnt <= rd_cnt + 1'b1;
            else
                rd_cnt <= '0;
            if (state == SN_RDL && rd_last)
                snap_lo <= m_readdata;
            if (state == SN_RDH && rd_last) begin
                snap_value <= {m_readdata, snap_lo};
                snap_valid <= 1'b1;
            end
        end
    end
`else
    assign snap_valid = 1'b0;
    assign snap_value = 32'h0000_0000;
`endif

endmodule

// File: tb/tb_timer_mm_master.sv
// Directed bench for timer_mm_master with a small s1 readdata model.
module tb_timer_mm_master;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic             cfg_valid;
    logic             cfg_ready;
    logic [31:0]      cfg_period;
    logic             cfg_continuous;
    logic             stop_req;
    logic             irq_in;
    logic [2:0]       m_address;
    logic             m_chipselect;
    logic             m_write_n;
    logic [15:0]      m_writedata;
    logic [15:0]      m_readdata = 16'h0000;
    logic             busy;
    logic [CNT_W-1:0] tick_count;
    logic             snap_valid;
    logic [31:0]      snap_value;

    int checks = 0;
    int errors = 0;

    timer_mm_master #(.READ_LATENCY(1), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_period(cfg_period), .cfg_continuous(cfg_continuous),
        .stop_req(stop_req), .irq_in(irq_in),
        .m_address(m_address), .m_chipselect(m_chipselect),
        .m_write_n(m_write_n), .m_writedata(m_writedata),
        .m_readdata(m_readdata), .busy(busy), .tick_count(tick_count),
        .snap_valid(snap_valid), .snap_value(snap_value)
    );

    always #5 clk = ~clk;

    // Slave readdata with one cycle of latency: reg4 = 0x0004, reg5 = 0x0001
    always @(posedge clk) begin
        if (m_chipselect && m_write_n)
            m_readdata <= (m_address == 3'd4) ? 16'h0004 :
                          (m_address == 3'd5) ? 16'h0001 : 16'h0000;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] bus_now();
        return {11'b0, m_chipselect, m_write_n, m_address, m_writedata};
    endfunction

    function automatic logic [31:0] bus_exp(input logic cs, input logic wn,
                                            input logic [2:0] a, input logic [15:0] d);
        return {11'b0, cs, wn, a, d};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_config(input logic [31:0] period, input logic cont);
        chk("cfg_ready_idle", cfg_ready, 1);
        cfg_period     = period;
        cfg_continuous = cont;
        cfg_valid      = 1'b1;
        tick();
        cfg_valid      = 1'b0;
        cfg_period     = 32'hDEAD_BEEF;
        cfg_continuous = ~cont;
        chk("w_stop", bus_now(), bus_exp(1, 0, 3'd1, 16'h0008));
        chk("cfg_ready_low", cfg_ready, 0);
        chk("busy_cfg", busy, 1);
        chk("tick_clr", tick_count, 0);
        tick();
        chk("w_clr0", bus_now(), bus_exp(1, 0, 3'd0, 16'h0000));
        tick();
        chk("w_pl", bus_now(), bus_exp(1, 0, 3'd2, period[15:0]));
        tick();
        chk("w_ph", bus_now(), bus_exp(1, 0, 3'd3, period[31:16]));
        tick();
        chk("w_ctrl", bus_now(), bus_exp(1, 0, 3'd1, cont ? 16'h0007 : 16'h0005));
        tick();
        chk("run_bus_idle", bus_now(), bus_exp(0, 1, 3'd0, 16'h0000));
        chk("run_busy", busy, 1);
        chk("run_cfg_ready", cfg_ready, 0);
    endtask

    // irq_in raised in RUN at cycle T and held through the guard cycle
    task automatic service_irq(input int exp_count, input logic cont);
        irq_in = 1'b1;
        tick();
        chk("s_clr", bus_now(), bus_exp(1, 0, 3'd0, 16'h0000));
        chk("tick_inc", tick_count, exp_count);
        tick();
        chk("s_guard", bus_now(), bus_exp(0, 1, 3'd0, 16'h0000));
        tick();
        irq_in = 1'b0;
`ifdef TIMER_MASTER_SNAPSHOT_EN
        chk("sn_wr", bus_now(), bus_exp(1, 0, 3'd4, 16'h0000));
        tick();
        chk("sn_rdl_a", bus_now(), bus_exp(1, 1, 3'd4, 16'h0000));
        tick();
        chk("sn_rdl_b", bus_now(), bus_exp(1, 1, 3'd4, 16'h0000));
        chk("snap_quiet", snap_valid, 0);
        tick();
        chk("sn_rdh_a", bus_now(), bus_exp(1, 1, 3'd5, 16'h0000));
        tick();
        chk("sn_rdh_b", bus_now(), bus_exp(1, 1, 3'd5, 16'h0000));
        tick();
        chk("snap_valid_t8", snap_valid, 1);
        chk("snap_value", snap_value, 32'h0001_0004);
        chk("snap_bus_idle", bus_now(), bus_exp(0, 1, 3'd0, 16'h0000));
        tick();
        chk("snap_valid_drop", snap_valid, 0);
`else
        chk("back_bus_idle", bus_now(), bus_exp(0, 1, 3'd0, 16'h0000));
        chk("snap_valid_off", snap_valid, 0);
        chk("snap_value_off", snap_value, 0);
`endif
        chk("after_busy", busy, cont);
        chk("after_cfg_ready", cfg_ready, !cont);
        chk("after_count", tick_count, exp_count);
    endtask

    initial begin
        reset          = 1'b1;
        cfg_valid      = 1'b0;
        cfg_period     = 32'h0;
        cfg_continuous = 1'b0;
        stop_req       = 1'b0;
        irq_in         = 1'b0;
        tick();
        tick();
        chk("rst_cfg_ready", cfg_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_tick", tick_count, 0);
        chk("rst_snap_valid", snap_valid, 0);
        chk("rst_snap_value", snap_value, 0);
        chk("rst_bus", bus_now(), bus_exp(0, 1, 3'd0, 16'h0000));
        reset = 1'b0;
        tick();

        // stop_req and irq_in are ignored outside RUN
        stop_req = 1'b1;
        irq_in   = 1'b1;
        tick();
        chk("idle_ignore_busy", busy, 0);
        chk("idle_ignore_bus", bus_now(), bus_exp(0, 1, 3'd0, 16'h0000));
        stop_req = 1'b0;
        irq_in   = 1'b0;
        tick();

        do_config(32'h0000_0009, 1'b1);
        service_irq(1, 1'b1);
        tick();
        service_irq(2, 1'b1);
        service_irq(3, 1'b1);
        tick();
        chk("run_stays_busy", busy, 1);
        chk("run_count3", tick_count, 3);

        // stop_req and irq_in together: halt write, count untouched
        stop_req = 1'b1;
        irq_in   = 1'b1;
        tick();
        stop_req = 1'b0;
        irq_in   = 1'b0;
        chk("w_halt", bus_now(), bus_exp(1, 0, 3'd1, 16'h0008));
        chk("halt_count", tick_count, 3);
        tick();
        chk("halt_bus_idle", bus_now(), bus_exp(0, 1, 3'd0, 16'h0000));
        chk("halt_busy", busy, 0);
        chk("halt_cfg_ready", cfg_ready, 1);
        chk("halt_count_kept", tick_count, 3);

        do_config(32'h0001_2345, 1'b0);
        service_irq(1, 1'b0);
        tick();

        // Reset while a timeout is being serviced
        do_config(32'h0000_0009, 1'b1);
        irq_in = 1'b1;
        tick();
        irq_in = 1'b0;
        chk("pre_reset_count", tick_count, 1);
        #2 reset = 1'b1;
        tick();
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_cfg_ready", cfg_ready, 1);
        chk("mid_rst_bus", bus_now(), bus_exp(0, 1, 3'd0, 16'h0000));
        chk("mid_rst_tick", tick_count, 0);
        chk("mid_rst_snap", snap_valid, 0);
        reset = 1'b0;
        tick();
        tick();
        chk("post_rst_idle", busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
